// File: rtl/iter_muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 opcodes and FSM states.
package iter_muldiv_unit_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   function automatic logic is_div_op(input md_op_e o);
      return o[2];
   endfunction

endpackage

// File: rtl/iter_muldiv_unit_md_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step (combinational).
module iter_muldiv_unit_md_step #(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   opnd,
   input  logic              div_mode,
   output logic [2*XLEN-1:0] acc_next,
   output logic              q_bit
);

   logic [XLEN:0] sum;
   logic [XLEN:0] diff;

   always_comb begin
      sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      // Shifted partial remainder needs XLEN+1 bits; the borrow bit decides the quotient bit.
      diff     = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
      q_bit    = 1'b0;
      acc_next = {sum, acc[XLEN-1:1]};
      if (div_mode) begin
         q_bit = ~diff[XLEN];
         if (q_bit)
            acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         else
            acc_next = {acc[2*XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/iter_muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit, XLEN iterations plus one fix-up cycle.
module iter_muldiv_unit
   import iter_muldiv_unit_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   md_state_e         state;
   md_op_e            op_q;
   md_op_e            op_in;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] step_acc;
   logic [XLEN-1:0]   opnd;
   logic              res_neg;
   logic              rem_neg;
   logic              q_bit;

   logic              sa, sb, b_zero, ovf, special;
   logic [XLEN-1:0]   ma, mb, spec_res, fix_res, quo, rem;
   logic [2*XLEN-1:0] prod;

   iter_muldiv_unit_md_step #(.XLEN(XLEN)) u_step (
      .acc      (acc),
      .opnd     (opnd),
      .div_mode (is_div_op(op_q)),
      .acc_next (step_acc),
      .q_bit    (q_bit)
   );

   always_comb begin
      op_in = md_op_e'(op);
      sa    = 1'b0;
      sb    = 1'b0;
      case (op_in)
         MD_MULH, MD_DIV, MD_REM: begin
            sa = a[XLEN-1];
            sb = b[XLEN-1];
         end
         MD_MULHSU: sa = a[XLEN-1];
         default: ;
      endcase
      ma      = sa ? -a : a;
      mb      = sb ? -b : b;
      b_zero  = (b == '0);
      ovf     = (op_in == MD_DIV || op_in == MD_REM) &&
                (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
      special = is_div_op(op_in) && (b_zero || ovf);
      spec_res = '0;
      if (b_zero)
         spec_res = (op_in == MD_DIV || op_in == MD_DIVU) ? '1 : a;
      else if (ovf)
         spec_res = (op_in == MD_DIV) ? a : '0;
   end

   // Sign fix-up: product negated at full width; remainder takes the dividend's sign.
   always_comb begin
      prod = res_neg ? -acc : acc;
      quo  = res_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem  = rem_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (op_q)
         MD_MUL:                       fix_res = prod[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              fix_res = quo;
         default:                      fix_res = rem;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= MD_IDLE;
         op_q    <= MD_MUL;
         cnt     <= '0;
         acc     <= '0;
         opnd    <= '0;
         res_neg <= 1'b0;
         rem_neg <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else begin
         done <= 1'b0;
         if (kill) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               MD_CALC: begin
                  acc <= step_acc | {{(2*XLEN-1){1'b0}}, q_bit};
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(XLEN-1))
                     state <= MD_FIX;
               end
               MD_FIX: begin
                  result <= fix_res;
                  state  <= MD_DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end
               default: begin
                  state <= MD_IDLE;
                  busy  <= 1'b0;
                  if (start) begin
                     if (special) begin
                        result <= spec_res;
                        state  <= MD_DONE;
                        done   <= 1'b1;
                     end else begin
                        op_q    <= op_in;
                        acc     <= {{XLEN{1'b0}}, ma};
                        opnd    <= mb;
                        res_neg <= sa ^ sb;
                        rem_neg <= sa;
                        cnt     <= '0;
                        state   <= MD_CALC;
                        busy    <= 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: doc/iter_muldiv_unit.md
Name: iter_muldiv_unit

Overview:
- Parametrised, multi-cycle RV32M/RV64M multiply/divide unit.
- Sits beside the single-cycle ALU in the execute stage and covers the M-extension operations the ALU lacks.
- Radix-2 iterative datapath with a start/busy/done handshake. A kill input lets the hazard/flush logic abandon an in-flight operation.
- The core stalls execute while busy=1.

Parameters:
- XLEN, 32, operand/result width; 32 or 64 only.
- CNT_W, $clog2(XLEN), iteration counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready (state IDLE or DONE).
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  input  XLEN  rs1 operand; captured on accepted start.
- b  input  XLEN  rs2 operand; captured on accepted start.
- kill  input  1  abort current operation; highest priority after rst.
- busy  output  1  high while in CALC or FIX.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  registered result; held until the next accepted start.

Behaviour:
- Reset:
  - rst=1 at a clock edge forces state=IDLE and clears busy, done, result and all internal registers.
  - Reset mid-operation discards the operation with no done pulse.
- States:
  - IDLE: accepts start and moves to CALC, or to DONE for the special cases below.
  - CALC: runs exactly XLEN iterations; count runs 0..XLEN-1, then goes to FIX.
  - FIX: applies sign correction and selects high/low half or quotient/remainder, writes result, goes to DONE.
  - DONE: done=1 for this cycle only. Next state is IDLE, or CALC/DONE if start=1 in this cycle (back-to-back issue).
- Latency: with start accepted in cycle 0 (normal path), busy is high in cycles 1..XLEN+1 and done=1 in cycle XLEN+2.
- Operand capture:
  - Signed ops store magnitudes plus result-sign flags.
  - MULHSU treats a as signed and b as unsigned.
  - The 2*XLEN product/remainder accumulator is internal.
- Multiply: shift-add, one multiplier bit per cycle.
  - MUL returns the low XLEN bits of the product.
  - MULH, MULHSU and MULHU return the high XLEN bits of the correctly signed product.
  - Negation of the 2*XLEN product happens in FIX.
- Divide: restoring, one quotient bit per cycle.
  - Quotient sign is sign(a) XOR sign(b).
  - Remainder sign follows the dividend.
- Special cases (detected at start, bypass CALC, done=1 in cycle 1):
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = a.
  - Signed overflow (DIV or REM with a = most negative value and b = -1): DIV result = a; REM result = 0.
- start while busy=1: ignored; no queueing; operands not recaptured.
- kill:
  - In CALC, FIX or DONE: next state IDLE, no done pulse, result unchanged.
  - kill and start in the same cycle: kill wins and the start is dropped.
- op, a and b are don't-care except in the cycle start is accepted.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Add to defines.v:
  - `MD_MUL .. `MD_REMU funct3 constants.
  - State encodings `MD_IDLE, `MD_CALC, `MD_FIX, `MD_DONE (2 bits).
- One natural sub-module: md_step, a combinational single radix-2 iteration.
  - Inputs: accumulator, operand, mode (mul/div).
  - Outputs: next accumulator and quotient bit.
  - Instantiated once in iter_muldiv_unit, which owns the FSM, counter, sign handling and result register.

Test Plan (XLEN=32):
- MUL a=7, b=-3 (0xFFFFFFFD): start in cycle 0 -> done only in cycle 34, result=0xFFFFFFEB, busy high cycles 1..33.
- MULH a=0x80000000, b=0x80000000 -> result=0x40000000. MULHU same operands -> 0x40000000. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> result=0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU same operands -> 2.
- DIVU a=5, b=0 -> done in cycle 1, result=0xFFFFFFFF. REM a=5, b=0 -> 5. DIV a=0x80000000, b=-1 -> 0x80000000. REM with the same operands -> 0.
- Kill at cycle 10 of a DIV -> no done pulse, busy low from cycle 11, result keeps its prior value. rst asserted at cycle 20 of a MUL -> all outputs 0 next cycle.
- Back-to-back: start=1 during the done cycle with a new MUL 3*4 -> second done exactly 34 cycles later, result=12. start pulses while busy are ignored (operands unchanged).
